booth_seq_mult: RTL and testbench
=================================

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal values are even and 4..32.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 Port start, input, 1 bit: request a multiply; sampled on rising clk.
REQ-005 Port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port a, input, WIDTH bits: multiplicand; sampled with start.
REQ-007 Port b, input, WIDTH bits: multiplier; sampled with start.
REQ-008 Port busy, output, 1 bit: high while a multiply is in progress.
REQ-009 Port done, output, 1 bit: single-cycle pulse when product is updated.
REQ-010 Port product, output, 2*WIDTH bits: last completed result, held stable until the next completion.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when step count reaches its final value; DONE->RUN on start, else DONE->IDLE.
REQ-012 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands, count or result.
REQ-013 On acceptance, a and b SHALL be extended to WIDTH+2 bits: sign-extended if is_signed=1, zero-extended otherwise.
REQ-014 Accumulator: upper half = 0, lower half = extended b, Booth history bit = 0, step counter = 0.
REQ-015 Radix-2 mode: each RUN cycle examines {multiplier LSB, history}: 01 adds extended a to the upper half, 10 subtracts it, 00/11 make no change.
REQ-016 Each step SHALL then arithmetic-right-shift the accumulator and history by one; the multiplier LSB becomes the new history.
REQ-017 Radix-2 mode SHALL perform exactly WIDTH+1 steps; done rises at the clock edge WIDTH+1 cycles after the accepting edge.
REQ-018 Accumulator arithmetic SHALL be at least 2*WIDTH+2 bits wide; product = low 2*WIDTH bits of the final accumulator.
REQ-019 Results SHALL be exact for all operand pairs in both modes; there is no overflow condition.
REQ-020 busy SHALL be 1 from the edge after acceptance up to and including the last RUN cycle, and 0 otherwise.
REQ-021 done and the product update SHALL occur on the same edge; done is high for exactly one cycle.
REQ-022 Start in DONE state SHALL be accepted on that same cycle (back-to-back); done falls and busy rises on the next edge.
REQ-023 Inputs a, b and is_signed changing during RUN SHALL NOT affect the result in progress.

Reset
REQ-024 With rst high on a rising edge: state = IDLE, busy = 0, done = 0, product = 0, counter = 0, accumulator = 0.
REQ-025 rst SHALL take priority over start; rst mid-RUN aborts the operation without asserting done or changing product from 0.
REQ-026 After rst deasserts, start SHALL be accepted on the first edge.

Configuration
REQ-027 Macro BOOTH_RADIX4_EN, when defined, SHALL select radix-4 (modified Booth) stepping.
REQ-028 Radix-4 mode: examine 3 bits {b1,b0,history} per step; add 0, +-a or +-2a, then shift by 2.
REQ-029 Radix-4 mode SHALL perform (WIDTH+2)/2 steps, so done arrives (WIDTH+2)/2 cycles after acceptance; results are identical to radix-2.
REQ-030 Without the macro, radix-2 stepping per REQ-015..REQ-017 SHALL be used, with no radix-4 logic present.

Verification (WIDTH=8)
REQ-031 Signed -128 x -128 -> product 0x4000; done exactly 9 cycles after acceptance (5 with BOOTH_RADIX4_EN).
REQ-032 Unsigned 255 x 255 -> 0xFE01; signed -1 x 1 -> 0xFFFF; signed 127 x -128 -> 0xC080.
REQ-033 start with new operands pulsed during RUN -> ignored; the original product completes on schedule.
REQ-034 Back-to-back: start held high at done (3x5, then 6x7) -> 0x000F, then 0x002A exactly 9 cycles later.
REQ-035 rst asserted at step 4 of a run -> busy=0, done never pulses, product=0; a new start then completes normally.
REQ-036 Random regression of 10k pairs in both modes, both macro settings -> product matches reference multiply.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier, signed or unsigned operands, one Booth step per clock.
// Define BOOTH_RADIX4_EN for radix-4 (modified Booth) stepping; the default build is radix-2.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int EW = WIDTH + 2;   // extended operand width
    localparam int UW = EW + 1;      // upper half keeps headroom for +-2a
    localparam int AW = UW + EW;
`ifdef BOOTH_RADIX4_EN
    localparam int NSTEPS = (WIDTH + 2) / 2;
    localparam int PLSB   = 0;
`else
    localparam int NSTEPS = WIDTH + 1;
    localparam int PLSB   = 1;       // one unconsumed multiplier bit stays below the product
`endif
    localparam int CW = $clog2(NSTEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [AW-1:0]        acc_q, acc_d;
    logic                 hist_q, hist_d;
    logic [UW-1:0]        mcand_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q, done_q;
    logic [2*WIDTH-1:0]   prod_q;

    logic [UW-1:0]        upper, upper_sum;
    logic [AW:0]          full, shifted;
    logic                 a_fill, b_fill;

    assign a_fill = is_signed & a[WIDTH-1];
    assign b_fill = is_signed & b[WIDTH-1];

    always_comb begin
        upper     = acc_q[AW-1:EW];
        upper_sum = upper;
`ifdef BOOTH_RADIX4_EN
        case ({acc_q[1:0], hist_q})
            3'b001, 3'b010: upper_sum = upper + mcand_q;
            3'b011:         upper_sum = upper + (mcand_q << 1);
            3'b100:         upper_sum = upper - (mcand_q << 1);
            3'b101, 3'b110: upper_sum = upper - mcand_q;
            default:        upper_sum = upper;
        endcase
        full    = {upper_sum, acc_q[EW-1:0], hist_q};
        shifted = $signed(full) >>> 2;
`else
        case ({acc_q[0], hist_q})
            2'b01:   upper_sum = upper + mcand_q;
            2'b10:   upper_sum = upper - mcand_q;
            default: upper_sum = upper;
        endcase
        full    = {upper_sum, acc_q[EW-1:0], hist_q};
        shifted = $signed(full) >>> 1;
`endif
        acc_d  = shifted[AW:1];
        hist_d = shifted[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            hist_q  <= 1'b0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    acc_q  <= acc_d;
                    hist_q <= hist_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NSTEPS - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        prod_q  <= acc_d[PLSB +: 2*WIDTH];
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        acc_q   <= {{UW{1'b0}}, {(EW-WIDTH){b_fill}}, b};
                        hist_q  <= 1'b0;
                        mcand_q <= {{(UW-WIDTH){a_fill}}, a};
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult at WIDTH=8.
// Latency expectations follow BOOTH_RADIX4_EN when it is defined for the build.
module tb_booth_seq_mult;

`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 9;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_chk  = 0;
    int n_fail = 0;

    booth_seq_mult #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic s, input logic [7:0] x, input logic [7:0] y, input string tag);
        @(negedge clk);
        start = 1'b1; is_signed = s; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_on_accept"}, busy, 1);
        chk({tag, "_done_on_accept"}, done, 0);
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [15:0] exp);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_product"}, product, exp);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic run(input logic s, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp, input string tag);
        launch(s, x, y, tag);
        wait_done(tag, LAT, exp);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_product_held"}, product, exp);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        @(negedge clk) rst = 1'b0;

        run(1'b1, 8'h80, 8'h80, 16'h4000, "s_m128_m128");
        run(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_255_255");
        run(1'b1, 8'hFF, 8'h01, 16'hFFFF, "s_m1_1");
        run(1'b1, 8'h7F, 8'h80, 16'hC080, "s_127_m128");
        run(1'b0, 8'hFF, 8'h01, 16'h00FF, "u_255_1");
        run(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_m1_m1");
        run(1'b0, 8'h80, 8'h80, 16'h4000, "u_128_128");
        run(1'b1, 8'h81, 8'h7F, 16'hC0FF, "s_m127_127");
        run(1'b1, 8'h85, 8'h03, 16'hFE8F, "s_m123_3");
        run(1'b0, 8'h00, 8'hAB, 16'h0000, "u_0_171");

        // start with new operands mid-run must be ignored
        launch(1'b0, 8'd5, 8'd6, "ignore");
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; a = 8'd9; b = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore", LAT - 3, 16'h001E);

        // back-to-back: start held high through the first run into DONE
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 8'd3; b = 8'd5;
        @(posedge clk); #1;
        chk("b2b_first_busy", busy, 1);
        wait_done("b2b_first", LAT, 16'h000F);
        a = 8'd6; b = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done_falls", done, 0);
        chk("b2b_busy_rises", busy, 1);
        wait_done("b2b_second", LAT, 16'h002A);

        // reset during step 4 aborts the run
        launch(1'b0, 8'd3, 8'd5, "abort");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        repeat (LAT + 2) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_product_stays", product, 0);
        chk("abort_idle_busy", busy, 0);

        // start accepted on the first edge after reset release
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; is_signed = 1'b0; a = 8'd12; b = 8'd11;
        @(posedge clk); #1;
        start = 1'b0;
        chk("post_rst_accept", busy, 1);
        wait_done("post_rst", LAT, 16'h0084);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
